// File: rtl/fpu_dispatch.sv
// FPU issue/retire sequencer: one request at a time, pulses the selected unit,
// retires results through a response FIFO with sticky fflags. Optional macro: FPU_TIMEOUT_EN.
module fpu_dispatch #(
    parameter int                   NUM_UNITS        = 11,
    parameter int                   XLEN             = 32,
    parameter int                   EXC_W            = 5,
    parameter int                   DEPTH            = 4,
    parameter logic [NUM_UNITS-1:0] MC_MASK          = 11'h600,
    parameter logic [NUM_UNITS-1:0] OP3_ILLEGAL_MASK = 11'h006,
    parameter int                   TIMEOUT          = 64
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [NUM_UNITS-1:0]           req_unit,
    input  logic [1:0]                     req_op,
    input  logic [2:0]                     req_rm,
    output logic [NUM_UNITS-1:0]           issue_valid,
    output logic [1:0]                     issue_op,
    output logic [2:0]                     issue_rm,
    input  logic [NUM_UNITS*XLEN-1:0]      unit_result,
    input  logic [NUM_UNITS*EXC_W-1:0]     unit_exc,
    input  logic [NUM_UNITS-1:0]           unit_done,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [XLEN-1:0]                rsp_data,
    output logic [EXC_W-1:0]               rsp_exc,
    output logic [$clog2(NUM_UNITS)-1:0]   rsp_unit,
    output logic                           rsp_illegal,
    output logic [EXC_W-1:0]               fflags,
    input  logic                           fflags_clr,
    output logic                           busy
);

    localparam int UW = $clog2(NUM_UNITS);
    localparam int AW = $clog2(DEPTH);
    localparam logic [NUM_UNITS-1:0] UNIT_ONE = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
        $error("fpu_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    typedef struct packed {
        logic             illegal;
        logic [UW-1:0]    unit;
        logic [EXC_W-1:0] exc;
        logic [XLEN-1:0]  data;
    } rsp_t;

    state_e           state_q, state_d;
    logic             ready_en_q;
    logic [UW-1:0]    unit_q, unit_d;
    logic [1:0]       op_q;
    logic [2:0]       rm_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EXC_W-1:0] fflags_q, fflags_d;
    rsp_t             mem [DEPTH];

    logic          req_onehot, req_illegal, req_mc, accept, push, pop, empty, full;
    logic [UW-1:0] req_idx;
    rsp_t          push_entry, head;

`ifdef FPU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Lowest set bit wins so a malformed select still reports a deterministic unit.
    always_comb begin
        req_idx = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (req_unit[i]) req_idx = UW'(i);
        end
    end

    assign req_onehot  = (req_unit != '0) && ((req_unit & (req_unit - UNIT_ONE)) == '0);
    assign req_illegal = !req_onehot || (OP3_ILLEGAL_MASK[req_idx] && req_op == 2'b11);
    assign req_mc      = MC_MASK[req_idx];

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign req_ready = ready_en_q && (state_q == S_IDLE) && !full;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_ready && !empty;

    assign issue_valid = (accept && !req_illegal) ? req_unit : '0;

    // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        push       = 1'b0;
        push_entry = '0;
`ifdef FPU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        push               = 1'b1;
                        push_entry.illegal = 1'b1;
                        push_entry.unit    = req_idx;
                    end else if (req_mc) begin
                        state_d = S_WAIT;
                        unit_d  = req_idx;
`ifdef FPU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        push            = 1'b1;
                        push_entry.unit = req_idx;
                        push_entry.data = unit_result[req_idx*XLEN +: XLEN];
                        push_entry.exc  = unit_exc[req_idx*EXC_W +: EXC_W];
                    end
                end
            end
            S_WAIT: begin
                if (unit_done[unit_q]) begin
                    push            = 1'b1;
                    push_entry.unit = unit_q;
                    push_entry.data = unit_result[unit_q*XLEN +: XLEN];
                    push_entry.exc  = unit_exc[unit_q*EXC_W +: EXC_W];
                    state_d         = S_IDLE;
`ifdef FPU_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // A hung unit retires as invalid-operation so software sees a trap, not a hang.
                    push                       = 1'b1;
                    push_entry.unit            = unit_q;
                    push_entry.exc             = '0;
                    push_entry.exc[EXC_W-1]    = 1'b1;
                    state_d                    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
    assign rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    assign fflags_d = (fflags_clr ? '0 : fflags_q) | (push ? push_entry.exc : '0);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
            unit_q     <= '0;
            op_q       <= '0;
            rm_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fflags_q   <= '0;
`ifdef FPU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            unit_q     <= unit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fflags_q   <= fflags_d;
`ifdef FPU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
            if (accept) begin
                op_q <= req_op;
                rm_q <= req_rm;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the empty flag masks stale entries on the outputs.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    assign head        = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign rsp_valid   = !empty;
    assign rsp_data    = head.data;
    assign rsp_exc     = head.exc;
    assign rsp_unit    = head.unit;
    assign rsp_illegal = head.illegal;
    assign fflags      = fflags_q;
    assign issue_op    = op_q;
    assign issue_rm    = rm_q;
    assign busy        = (state_q == S_WAIT);

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: queue-based reference model checked every
// cycle, plus directed literal expectations that pin the model.
module tb_fpu_dispatch;

    localparam int NUM_UNITS = 11;
    localparam int XLEN      = 32;
    localparam int EXC_W     = 5;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 8;
    localparam logic [NUM_UNITS-1:0] MC  = 11'h600;
    localparam logic [NUM_UNITS-1:0] OP3 = 11'h006;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [NUM_UNITS-1:0] req_unit = '0;
    logic [1:0] req_op = '0;
    logic [2:0] req_rm = '0;
    logic [NUM_UNITS-1:0] issue_valid;
    logic [1:0] issue_op;
    logic [2:0] issue_rm;
    logic [NUM_UNITS*XLEN-1:0] unit_result;
    logic [NUM_UNITS*EXC_W-1:0] unit_exc;
    logic [NUM_UNITS-1:0] unit_done = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_data;
    logic [EXC_W-1:0] rsp_exc;
    logic [3:0] rsp_unit;
    logic rsp_illegal;
    logic [EXC_W-1:0] fflags;
    logic fflags_clr = 1'b0;
    logic busy;

    logic [XLEN-1:0]  res  [NUM_UNITS];
    logic [EXC_W-1:0] uexc [NUM_UNITS];

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_pack
        assign unit_result[g*XLEN +: XLEN]   = res[g];
        assign unit_exc[g*EXC_W +: EXC_W]    = uexc[g];
    end

    fpu_dispatch #(
        .NUM_UNITS(NUM_UNITS), .XLEN(XLEN), .EXC_W(EXC_W), .DEPTH(DEPTH),
        .MC_MASK(MC), .OP3_ILLEGAL_MASK(OP3), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
        .req_op(req_op), .req_rm(req_rm),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rm(issue_rm),
        .unit_result(unit_result), .unit_exc(unit_exc), .unit_done(unit_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_exc(rsp_exc), .rsp_unit(rsp_unit), .rsp_illegal(rsp_illegal),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [XLEN-1:0]  data;
        logic [EXC_W-1:0] exc;
        int               unit;
        bit               illegal;
    } ent_t;

    ent_t             mq[$];
    bit               m_ready_en = 0;
    bit               m_busy = 0;
    int               m_unit = 0;
    int               m_cycles = 0;
    logic [EXC_W-1:0] m_fflags = '0;

    function automatic int lowest(input logic [NUM_UNITS-1:0] u);
        for (int i = 0; i < NUM_UNITS; i++) if (u[i]) return i;
        return 0;
    endfunction

    function automatic bit is_illegal(input logic [NUM_UNITS-1:0] u, input logic [1:0] op);
        return ($countones(u) != 1) || (OP3[lowest(u)] && op == 2'b11);
    endfunction

    function automatic bit model_ready();
        return m_ready_en && !m_busy && (mq.size() < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mq.delete();
            m_ready_en = 0;
            m_busy     = 0;
            m_unit     = 0;
            m_cycles   = 0;
            m_fflags   = '0;
        end else begin
            bit   acc, do_pop, pushed;
            ent_t e;
            int   u;
            acc    = req_valid && model_ready();
            do_pop = rsp_ready && (mq.size() > 0);
            pushed = 0;
            e      = '{data: '0, exc: '0, unit: 0, illegal: 0};
            if (acc) begin
                u = lowest(req_unit);
                if (is_illegal(req_unit, req_op)) begin
                    pushed = 1; e.unit = u; e.illegal = 1;
                end else if (MC[u]) begin
                    m_busy = 1; m_unit = u; m_cycles = 0;
                end else begin
                    pushed = 1; e.unit = u; e.data = res[u]; e.exc = uexc[u];
                end
            end else if (m_busy) begin
                if (unit_done[m_unit]) begin
                    pushed = 1; e.unit = m_unit; e.data = res[m_unit]; e.exc = uexc[m_unit];
                    m_busy = 0;
`ifdef FPU_TIMEOUT_EN
                end else if (m_cycles == TIMEOUT - 1) begin
                    pushed = 1; e.unit = m_unit; e.exc = 5'b10000;
                    m_busy = 0;
`endif
                end else begin
                    m_cycles++;
                end
            end
            m_fflags = (fflags_clr ? '0 : m_fflags) | (pushed ? e.exc : '0);
            if (do_pop) void'(mq.pop_front());
            if (pushed) mq.push_back(e);
            m_ready_en = 1;
        end
    end

    // One compare process on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        logic [NUM_UNITS-1:0] exp_issue;
        ent_t h;
        h = '{data: '0, exc: '0, unit: 0, illegal: 0};
        if (mq.size() > 0) h = mq[0];
        exp_issue = (req_valid && model_ready() && !is_illegal(req_unit, req_op)) ? req_unit : '0;
        check("req_ready",   req_ready,   model_ready());
        check("issue_valid", issue_valid, exp_issue);
        check("busy",        busy,        m_busy);
        check("fflags",      fflags,      m_fflags);
        check("rsp_valid",   rsp_valid,   mq.size() > 0);
        check("rsp_data",    rsp_data,    h.data);
        check("rsp_exc",     rsp_exc,     h.exc);
        check("rsp_unit",    rsp_unit,    h.unit);
        check("rsp_illegal", rsp_illegal, h.illegal);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [NUM_UNITS-1:0] u, input logic [1:0] op, input logic [2:0] rm);
        req_valid = 1'b1; req_unit = u; req_op = op; req_rm = rm;
    endtask

    initial begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            res[i]  = '0;
            uexc[i] = '0;
        end

        // Reset
        repeat (3) tick();
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_issue_op",  {issue_op, issue_rm}, 5'd0);
        rst_l = 1'b1;
        tick();
        check("ready_after_release", req_ready, 1'b1);

        // Single-cycle add
        res[6] = 32'h40400000;
        request(11'd1 << 6, 2'b00, 3'b000);
        #1;
        check("add_issue_strobe", issue_valid, 11'd1 << 6);
        tick();
        req_valid = 1'b0;
        check("add_rsp_valid", rsp_valid, 1'b1);
        check("add_rsp_data",  rsp_data, 32'h40400000);
        check("add_rsp_unit",  rsp_unit, 4'd6);
        check("add_fflags",    fflags, 5'b00000);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Divide with done 12 cycles after accept; a stray done on unit 10 is ignored
        request(11'd1 << 9, 2'b01, 3'b011);
        tick();
        req_valid = 1'b0;
        check("div_issue_op", {issue_op, issue_rm}, {2'b01, 3'b011});
        for (int i = 0; i < 12; i++) begin
            check("div_busy",      busy, 1'b1);
            check("div_not_ready", req_ready, 1'b0);
            unit_done = '0;
            if (i == 3) unit_done[10] = 1'b1;
            if (i == 11) begin
                res[9] = 32'h3F000000; uexc[9] = 5'b00001; unit_done[9] = 1'b1;
            end
            tick();
        end
        unit_done = '0;
        check("div_busy_drop", busy, 1'b0);
        check("div_rsp_data",  rsp_data, 32'h3F000000);
        check("div_fflags",    fflags, 5'b00001);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Illegal: compare with op 3, then a two-hot select
        res[2] = 32'hDEADBEEF;
        request(11'd1 << 2, 2'b11, 3'b000);
        #1;
        check("illegal_no_issue", issue_valid, 11'd0);
        tick();
        check("illegal_flag", rsp_illegal, 1'b1);
        check("illegal_data", rsp_data, 32'h0);
        check("illegal_unit", rsp_unit, 4'd2);
        request(11'h003, 2'b00, 3'b000);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("twohot_flag", rsp_illegal, 1'b1);
        check("twohot_unit", rsp_unit, 4'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // Backpressure: fill four entries, a fifth waits, then push+pop together
        res[0] = 32'd11; res[3] = 32'd33; res[4] = 32'd44; res[5] = 32'd55; res[8] = 32'd88;
        request(11'd1 << 0, 2'b00, 3'b000); tick();
        request(11'd1 << 3, 2'b00, 3'b000); tick();
        request(11'd1 << 4, 2'b00, 3'b000); tick();
        request(11'd1 << 5, 2'b00, 3'b000); tick();
        check("full_not_ready", req_ready, 1'b0);
        request(11'd1 << 8, 2'b00, 3'b000); tick();
        check("full_head", rsp_data, 32'd11);
        rsp_ready = 1'b1; tick();
        check("after_pop_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("pushpop_head", rsp_data, 32'd44);
        rsp_ready = 1'b1;
        check("drain0", rsp_data, 32'd44); tick();
        check("drain1", rsp_data, 32'd55); tick();
        check("drain2", rsp_data, 32'd88); tick();
        check("drain_empty", rsp_valid, 1'b0);
        rsp_ready = 1'b0;

        // fflags clear, clear coincident with push, clear alone
        fflags_clr = 1'b1; tick();
        check("clr_alone", fflags, 5'b00000);
        uexc[7] = 5'b00100;
        request(11'd1 << 7, 2'b00, 3'b000);
        tick();
        req_valid = 1'b0;
        check("clr_with_push", fflags, 5'b00100);
        tick();
        fflags_clr = 1'b0;
        check("clr_again", fflags, 5'b00000);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

`ifdef FPU_TIMEOUT_EN
        // Sqrt with no done: times out after TIMEOUT wait cycles
        begin
            int n;
            request(11'd1 << 10, 2'b00, 3'b000);
            tick();
            req_valid = 1'b0;
            n = 0;
            while (busy && n < 40) begin
                tick();
                n++;
            end
            check("timeout_cycles", n, 8);
            check("timeout_exc",  rsp_exc, 5'b10000);
            check("timeout_unit", rsp_unit, 4'd10);
            check("timeout_data", rsp_data, 32'h0);
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        end
`endif

        // Reset mid-operation drops FIFO contents and the in-flight divide
        request(11'd1 << 6, 2'b00, 3'b000); tick();
        request(11'd1 << 9, 2'b00, 3'b000); tick();
        req_valid = 1'b0;
        tick();
        rst_l = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_busy",      busy, 1'b0);
        check("midrst_ready",     req_ready, 1'b0);
        tick();
        rst_l = 1'b1;
        tick();
        res[6] = 32'h12345678;
        request(11'd1 << 6, 2'b10, 3'b001); tick();
        req_valid = 1'b0;
        check("recover_data", rsp_data, 32'h12345678);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
